// File: rtl/pipelined_multiplier.sv
// Unsigned multiplier returning the low DATA_LEN bits of a*b, built from a chunked shift-add pipeline.
// Latency: PIPELINE_STAGE-1 clk edges. A value of 1 makes it purely combinational. One new operand pair per cycle.
// No backpressure: there is no handshake, and the pipeline advances on every clk edge.
module pipelined_multiplier #(
   parameter int DATA_LEN       = 32,
   parameter int PIPELINE_STAGE = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_LEN-1:0] a,
   input  logic [DATA_LEN-1:0] b,
   output logic [DATA_LEN-1:0] result
);

   // Width of the b slice consumed per stage. The final stage takes whatever is left.
   localparam int CHUNK = DATA_LEN / PIPELINE_STAGE;
   // Selects the low CHUNK bits of the remaining multiplier. CHUNK == DATA_LEN yields all ones.
   localparam logic [DATA_LEN-1:0] CHUNK_MASK = ~({DATA_LEN{1'b1}} << CHUNK);

   // Inputs seen by each stage: running sum, multiplicand, and b shifted so its unconsumed bits sit at bit 0.
   logic [DATA_LEN-1:0] stg_sum [PIPELINE_STAGE];
   logic [DATA_LEN-1:0] stg_a   [PIPELINE_STAGE];
   logic [DATA_LEN-1:0] stg_b   [PIPELINE_STAGE];

   // Outputs of each stage, captured by the next register rank.
   logic [DATA_LEN-1:0] nxt_sum [PIPELINE_STAGE];
   logic [DATA_LEN-1:0] nxt_b   [PIPELINE_STAGE];
   logic [DATA_LEN-1:0] chunk;

   // Stage 0 is fed directly from the ports, with no input register.
   assign stg_sum[0] = '0;
   assign stg_a[0]   = a;
   assign stg_b[0]   = b;

   // Each stage adds a * (its chunk of b), shifted into place, to the running sum modulo 2^DATA_LEN.
   always_comb begin
      chunk = '0;
      for (int i = 0; i < PIPELINE_STAGE; i++) begin
         chunk      = (i == PIPELINE_STAGE - 1) ? stg_b[i] : (stg_b[i] & CHUNK_MASK);
         nxt_sum[i] = stg_sum[i] + ((stg_a[i] * chunk) << (i * CHUNK));
         nxt_b[i]   = stg_b[i] >> CHUNK;
      end
   end

   generate
      if (PIPELINE_STAGE > 1) begin : g_pipe
         logic [DATA_LEN-1:0] rk_sum [PIPELINE_STAGE-1];
         logic [DATA_LEN-1:0] rk_a   [PIPELINE_STAGE-1];
         logic [DATA_LEN-1:0] rk_b   [PIPELINE_STAGE-1];

         // Register ranks between stages. Reset flushes every slot to zero, so result reads 0.
         always_ff @(posedge clk) begin
            for (int r = 0; r < PIPELINE_STAGE - 1; r++) begin
               if (!reset) begin
                  rk_sum[r] <= '0;
                  rk_a[r]   <= '0;
                  rk_b[r]   <= '0;
               end else begin
                  rk_sum[r] <= nxt_sum[r];
                  rk_a[r]   <= stg_a[r];
                  rk_b[r]   <= nxt_b[r];
               end
            end
         end

         for (genvar s = 1; s < PIPELINE_STAGE; s++) begin : g_feed
            assign stg_sum[s] = rk_sum[s-1];
            assign stg_a[s]   = rk_a[s-1];
            assign stg_b[s]   = rk_b[s-1];
         end
      end
   endgenerate

   // The final stage is combinational from the last rank (or from the ports when there are no ranks).
   assign result = nxt_sum[PIPELINE_STAGE-1];

endmodule

// File: tb/tb_pipelined_multiplier.sv
module tb_pipelined_multiplier;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] result;

   logic [15:0] r_s1_16, r_s2_16, r_s4_16;
   logic [31:0] r_s1_32, r_s4_32;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q [$];
   logic [63:0] op_q  [$];

   // Instance 0 is the default DUT. The others cover the parameter sweep and share the same operand bus.
   logic [31:0] sw_res [6];
   int          sw_d   [6] = '{0, 0, 0, 2, 0, 2};
   int          sw_dl  [6] = '{32, 16, 16, 16, 32, 32};

   always #5 clk = ~clk;

   pipelined_multiplier dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .result(result));

   pipelined_multiplier #(.DATA_LEN(16), .PIPELINE_STAGE(1)) u_s1_16 (
      .clk(clk), .reset(reset), .a(a[15:0]), .b(b[15:0]), .result(r_s1_16));
   pipelined_multiplier #(.DATA_LEN(16), .PIPELINE_STAGE(2)) u_s2_16 (
      .clk(clk), .reset(reset), .a(a[15:0]), .b(b[15:0]), .result(r_s2_16));
   pipelined_multiplier #(.DATA_LEN(16), .PIPELINE_STAGE(4)) u_s4_16 (
      .clk(clk), .reset(reset), .a(a[15:0]), .b(b[15:0]), .result(r_s4_16));
   pipelined_multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(1)) u_s1_32 (
      .clk(clk), .reset(reset), .a(a), .b(b), .result(r_s1_32));
   pipelined_multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(4)) u_s4_32 (
      .clk(clk), .reset(reset), .a(a), .b(b), .result(r_s4_32));

   assign sw_res[0] = result;
   assign sw_res[1] = {16'h0, r_s1_16};
   assign sw_res[2] = {16'h0, r_s2_16};
   assign sw_res[3] = {16'h0, r_s4_16};
   assign sw_res[4] = r_s1_32;
   assign sw_res[5] = r_s4_32;

   // Drive one operand pair (and reset level) on the falling edge and record the expected result.
   task automatic drive(input logic [31:0] av, input logic [31:0] bv,
                        input logic rst, input logic [31:0] expv);
      @(negedge clk);
      a = av;
      b = bv;
      reset = rst;
      exp_q.push_back(expv);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 6; k++) begin
         total++;
         if (sw_res[k] !== 32'h0) begin
            bad++;
            $display("FAIL reset_state inst%0d: result=%h expected=%h", k, sw_res[k], 32'h0);
         end
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_basic;
      logic [31:0] e;
      drive(32'd7, 32'd6, 1'b1, 32'd42);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (result !== e) begin
         bad++;
         $display("FAIL basic_product: result=%0d expected=%0d", result, e);
      end
      drive(32'd0, 32'd0, 1'b1, 32'd0);
      #1;
      total++;
      if (result !== 32'd42) begin
         bad++;
         $display("FAIL basic_hold_after_operand_change: result=%0d expected=42", result);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (result !== e) begin
         bad++;
         $display("FAIL basic_zero_follow: result=%0d expected=%0d", result, e);
      end
   endtask

   task automatic test_truncation;
      logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF};
      logic [31:0] vb [3] = '{32'h0000_0002, 32'h0001_0000, 32'hFFFF_FFFF};
      logic [31:0] ve [3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0001};
      logic [31:0] e;
      for (int i = 0; i < 3; i++) begin
         drive(va[i], vb[i], 1'b1, ve[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if (result !== e) begin
            bad++;
            $display("FAIL truncation%0d: result=%h expected=%h", i, result, e);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] va [3] = '{32'd3, 32'd100, 32'h1234_5678};
      logic [31:0] vb [3] = '{32'd5, 32'd200, 32'd1};
      logic [31:0] ve [3] = '{32'd15, 32'd20000, 32'h1234_5678};
      logic [31:0] e;
      for (int i = 0; i < 3; i++) begin
         drive(va[i], vb[i], 1'b1, ve[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if (result !== e) begin
            bad++;
            $display("FAIL back_to_back%0d: result=%h expected=%h", i, result, e);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic       rs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] ve [4] = '{32'd81, 32'd0, 32'd0, 32'd81};
      logic [31:0] e;
      for (int i = 0; i < 4; i++) begin
         drive(32'd9, 32'd9, rs[i], ve[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if (result !== e) begin
            bad++;
            $display("FAIL reset_mid step%0d: result=%0d expected=%0d", i, result, e);
         end
      end
   endtask

   task automatic test_zero_identity;
      logic [31:0] va [3] = '{32'h0, 32'h1, 32'hDEAD_BEEF};
      logic [31:0] vb [3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1};
      logic [31:0] ve [3] = '{32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      logic [31:0] e;
      for (int i = 0; i < 3; i++) begin
         drive(va[i], vb[i], 1'b1, ve[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total++;
         if (result !== e) begin
            bad++;
            $display("FAIL zero_identity%0d: result=%h expected=%h", i, result, e);
         end
      end
   endtask

   // Random streaming into all instances. Each instance's expected value comes from the operand history
   // at its own depth. Depth 2 means the result at the sample after edge k belongs to the pair sampled at edge k-2.
   task automatic test_sweep;
      logic [63:0] pair;
      logic [31:0] prod, e;
      op_q.delete();
      for (int n = 0; n < 1200; n++) begin
         @(negedge clk);
         a = $urandom;
         b = $urandom;
         if (n % 37 == 0) a = 32'hFFFF_FFFF;
         if (n % 41 == 0) b = 32'hFFFF_FFFF;
         if (n % 53 == 0) b = 32'h0;
         op_q.push_back({a, b});
         @(posedge clk); #1;
         for (int k = 0; k < 6; k++) begin
            if (op_q.size() > sw_d[k]) begin
               pair = op_q[op_q.size() - 1 - sw_d[k]];
               prod = pair[63:32] * pair[31:0];
               e = (sw_dl[k] == 16) ? {16'h0, prod[15:0]} : prod;
               total++;
               if (sw_res[k] !== e) begin
                  bad++;
                  $display("FAIL sweep inst%0d vec%0d: result=%h expected=%h", k, n, sw_res[k], e);
               end
            end
         end
         if (op_q.size() > 8) void'(op_q.pop_front());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_truncation();
      test_back_to_back();
      test_reset_mid();
      test_zero_identity();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipelined_multiplier.md
# pipelined_multiplier

Unsigned integer multiplier producing the low DATA_LEN bits of a × b through a fixed-depth, fully pipelined datapath. It sits in the slow-clock compute domain behind the operand/result clock-crossing FIFOs. It accepts a new operand pair every cycle and has no handshake. Callers schedule result capture purely by the fixed latency.

## Interface
- DATA_LEN, default 32: operand and result width in bits (legal 8..64).
- PIPELINE_STAGE, default 2: pipeline depth; the datapath holds PIPELINE_STAGE−1 register ranks (legal 1..8; 1 = purely combinational).
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; 0 sampled at a rising edge clears all state.
- a  input  DATA_LEN  multiplicand, unsigned.
- b  input  DATA_LEN  multiplier, unsigned.
- result  output  DATA_LEN  (a × b) mod 2^DATA_LEN for the operands sampled PIPELINE_STAGE−1 edges earlier.

## Operation
- Arithmetic:
  - result is the low DATA_LEN bits of the unsigned 2·DATA_LEN product; upper bits are discarded with no overflow flag.
  - The low bits are identical for two's-complement operands, so signed use is permitted.
- Datapath:
  - b is split into PIPELINE_STAGE contiguous chunks, LSB first. The last chunk absorbs the remainder when DATA_LEN is not divisible.
  - Stage i adds the partial product a × chunk_i, shifted into position, to the running sum. The running sum is truncated to DATA_LEN bits.
  - a and the unconsumed part of b travel with the sum through each register rank.
  - Stage 0 is fed directly from a and b, with no separate input register.
  - The final stage is combinational and drives result.
- Ranks and throughput:
  - There are exactly PIPELINE_STAGE−1 register ranks between a/b and result.
  - Throughput is one operation per cycle.
  - Operations never interact; each pipeline slot is independent.
- Reset:
  - While reset=0, every pipeline register loads 0 on each rising edge.
  - result therefore reads 0 from the first edge after reset assertion. For PIPELINE_STAGE=1, result is a×b combinationally at all times.
  - After reset deasserts, the first valid result corresponds to the operands sampled at the first edge with reset=1.
- No enable, stall or valid signals exist; the pipeline advances on every edge.

## Timing
- Latency is L = PIPELINE_STAGE−1 edges.
  - Operands present at edge k determine result during the cycle after edge k+L−1.
  - Equivalently, result is stable and sampleable at edge k+L.
- Default PIPELINE_STAGE=2 (L=1):
  - Operands applied before edge k are registered at edge k.
  - result shows their product after edge k, and it is captured correctly at edge k+1.
  - Operands may change, for example to 0, immediately after edge k without corrupting that result.
- result changes only after a rising clk edge, never from combinational a/b changes, except when PIPELINE_STAGE=1.
- Reset mid-operation:
  - In-flight products are lost and are not recovered.
  - result reads 0 until new operands propagate.
- The critical path is one DATA_LEN × chunk partial product plus one DATA_LEN-bit adder per stage.

## Test plan
- Basic product (default parameters), reset=1:
  - Apply a=7, b=6 for one edge, then a=b=0.
  - result = 42 at the next sampling edge, then 0 one edge later.
- Truncation:
  - a=0xFFFFFFFF, b=2 → result = 0xFFFFFFFE.
  - a=0x00010000, b=0x00010000 → result = 0x00000000.
  - a=0xFFFFFFFF, b=0xFFFFFFFF → result = 0x00000001.
- Back-to-back streaming:
  - Apply (3,5), (100,200), (0x12345678,1) on consecutive edges.
  - result = 15, 20000, 0x12345678 on consecutive cycles with latency exactly 1.
- Reset behaviour:
  - Load a=9, b=9, then assert reset=0 for 2 edges while holding the operands.
  - result = 0 after the first reset edge.
  - After release, result = 81 one edge later.
- Parameter sweep:
  - PIPELINE_STAGE ∈ {1,2,4} with DATA_LEN ∈ {16,32}, random operands (≥1000 vectors).
  - result matches (a*b) mod 2^DATA_LEN, delayed by exactly PIPELINE_STAGE−1 edges.
- Zero/identity:
  - a=0, b=0xDEADBEEF → 0.
  - a=1, b=0xDEADBEEF → 0xDEADBEEF.
  - a=0xDEADBEEF, b=1 → 0xDEADBEEF.
